hierarchical_dot_dec: RTL and testbench
=======================================

# hierarchical_dot_dec

Streaming decoder for the hierarchical-dot code path, where each encoded byte is `code = 2*x + 1 (mod 2^W)`. It accepts code words over a valid/ready handshake, recovers the low `W-1` bits of `x`, flags malformed (even) code words, and tracks frame and error statistics. It sits on the receive side of the code path, directly downstream of the encoder, and buffers up to two decoded beats.

## Interface
- `W`, default 8: code width in bits, must be at least 2.
- `CNT_W`, default 8: width of the statistics counters.

- `clk`  in  1: clock; everything is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: a code word is offered.
- `in_ready`  out  1: the block can accept a code word.
- `in_code`  in  W: the encoded word.
- `in_last`  in  1: this beat ends the frame.
- `out_valid`  out  1: a decoded beat is available.
- `out_ready`  in  1: downstream accepts the beat.
- `out_val`  out  W-1: the decoded value.
- `out_err`  out  1: the beat's code word was even (malformed).
- `out_last`  out  1: `in_last` forwarded with the beat.
- `err_count`  out  CNT_W: number of malformed beats accepted, saturating.
- `frame_count`  out  CNT_W: number of completed frames, wrapping.
- `busy`  out  1: a frame is open, or output data is pending.

## Operation
- **Accept:** a beat is accepted when `in_valid && in_ready`. A beat is delivered when `out_valid && out_ready`.
- **Decode:** `out_val = in_code[W-1:1]`. This equals `(code-1)>>1` for odd codes. The MSB of `x` cannot be recovered and is dropped.
- **Error:** `out_err = ~in_code[0]`. A malformed beat is still forwarded with `out_val = in_code[W-1:1]`.
- **Buffer:** a 2-entry FIFO holds `{out_val, out_err, out_last}`. Order is preserved.
- **in_ready:** equals `count < 2`, where `count` is the registered occupancy. When `count == 2`, no beat is accepted, even if a pop happens in the same cycle.
- **Simultaneous push and pop:** when `count` is 1, occupancy stays 1 and data order is preserved.
- **FSM states:** IDLE (no open frame) and FRAME (at least one beat of the current frame has been accepted).
  - IDLE → FRAME: accepted beat with `in_last == 0`.
  - FRAME → IDLE: accepted beat with `in_last == 1`.
  - IDLE, accepted beat with `in_last == 1`: a single-beat frame; stay in IDLE.
- **frame_count:** increments on every accepted beat with `in_last == 1`. It wraps from `2^CNT_W-1` to 0.
- **err_count:** increments on every accepted beat with `in_code[0] == 0`. It saturates at `2^CNT_W-1`.
- **busy:** `(state == FRAME) || (count != 0)`.
- **Reset values:** `in_ready` 1, `out_valid` 0, `out_val` 0, `out_err` 0, `out_last` 0, `err_count` 0, `frame_count` 0, `busy` 0, FSM in IDLE, FIFO empty.
- **Reset mid-frame:** the open frame is abandoned with no count increment, and buffered beats are discarded.

## Timing
- **Latency:** a beat accepted in cycle N, with the FIFO empty, presents on `out_valid` in cycle N+1.
- **Counters:** `err_count` and `frame_count` update in cycle N+1 for a beat accepted in cycle N.
- **Throughput:** one beat per cycle while `out_ready` is held at 1.
- **Backpressure:** with `out_ready == 0`, two beats are accepted, then `in_ready` drops in the cycle after the second push.
- **in_ready recovery:** `in_ready` returns to 1 in the cycle after the first pop.
- **Output stability:** `out_*` hold stable while `out_valid && !out_ready`.

## Structure
- **Package `hdd_pkg`:**
  - typedef `hdd_state_e` with values IDLE and FRAME.
  - packed struct `hdd_beat_t` with fields `val`, `err`, `last`.
  - constant `HDD_FIFO_DEPTH = 2`.
- **Sub-module `hdd_skid_fifo`:** the 2-entry FIFO, parameterised on the beat width. It exposes `count`, `push`, `pop` and the head entry.
- **Decode logic:** a named `always_comb` block with static locals. The inner named block refers to the outer local through its hierarchical name, consistent with the rest of the Lookup path.

## Test plan
- **Basic decode:** with `out_ready = 1`, send codes `8'h03`, `8'hFF`, `8'h01`, the last with `in_last = 1`.
  - Expect `out_val` 7'h01, 7'h7F, 7'h00, each one cycle after acceptance.
  - Expect `out_err = 0`, `frame_count = 1`, FSM ends in IDLE.
- **Malformed code:** send code `8'h04` with `in_last = 1`.
  - Expect `out_val = 7'h02`, `out_err = 1`, `err_count = 1`, `frame_count = 1`.
- **Backpressure:** hold `out_ready = 0` and offer codes 3, 5, 7.
  - Expect two beats accepted, `in_ready = 0`, and code 7 held.
  - Raise `out_ready`: expect outputs 1, 2, 3 in order, with nothing lost or duplicated.
- **Counter limits:** send 256 single-beat frames of `8'h00`.
  - Expect `err_count` saturated at 8'hFF and `frame_count` wrapped to 8'h00.
- **Mid-frame reset:** send 2 beats with `in_last = 0`, then assert `rst` for one cycle.
  - Expect `out_valid = 0`, `busy = 0`, counters 0, FSM in IDLE.
  - The next single-beat frame must count as `frame_count = 1`.
- **Simultaneous push and pop:** with `count = 1`, push and pop in the same cycle.
  - Expect `count` to stay 1, `in_ready` to stay 1, and the FIFO order to be kept.

Source files
------------

// File: rtl/hdd_pkg.sv
// Shared types and constants for the hierarchical-dot decode path.
package hdd_pkg;

    localparam int unsigned HDD_FIFO_DEPTH = 2;
    localparam int unsigned HDD_DEF_W      = 8;

    typedef enum logic {
        IDLE,
        FRAME
    } hdd_state_e;

    // Beat layout at the default code width; wider instances use the same field order.
    typedef struct packed {
        logic [HDD_DEF_W-2:0] val;
        logic                 err;
        logic                 last;
    } hdd_beat_t;

endpackage

// File: rtl/hdd_skid_fifo.sv
// Two-entry FIFO holding decoded beats; the caller guarantees no push when full and no pop when empty.
module hdd_skid_fifo
    import hdd_pkg::*;
#(
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [HDD_FIFO_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < HDD_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/hierarchical_dot_dec.sv
// Streaming decoder for code = 2*x + 1: recovers x[W-2:0], flags even codes, counts frames and errors.
module hierarchical_dot_dec
    import hdd_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_code,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-2:0]     out_val,
    output logic             out_err,
    output logic             out_last,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy
);

    // Same field order as hdd_beat_t, sized to this instance's code width.
    typedef struct packed {
        logic [W-2:0] val;
        logic         err;
        logic         last;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);

    hdd_state_e        state;
    hdd_state_e        state_next;
    beat_t             push_beat;
    beat_t             head_beat;
    logic [BEAT_W-1:0] head_bits;
    logic [1:0]        count;
    logic              accept;
    logic              deliver;

    assign in_ready  = (count < 2'(HDD_FIFO_DEPTH));
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin : decode
        logic [W-2:0] dec_val;
        dec_val   = in_code[W-1:1];
        push_beat = '0;
        begin : assemble
            push_beat.val  = decode.dec_val;
            push_beat.err  = ~in_code[0];
            push_beat.last = in_last;
        end
    end

    hdd_skid_fifo #(
        .DW(BEAT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_data(push_beat),
        .pop      (deliver),
        .head     (head_bits),
        .count    (count)
    );

    assign head_beat = beat_t'(head_bits);
    assign out_val   = head_beat.val;
    assign out_err   = head_beat.err;
    assign out_last  = head_beat.last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = in_last ? IDLE : FRAME;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count   <= '0;
            frame_count <= '0;
        end else if (accept) begin
            if (!in_code[0] && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (in_last) begin
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

    assign busy = (state == FRAME) || (count != 2'd0);

endmodule

// File: tb/tb_hierarchical_dot_dec.sv
// Directed bench for hierarchical_dot_dec at W=8, CNT_W=8.
module tb_hierarchical_dot_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_code = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] out_val;
    logic       out_err;
    logic       out_last;
    logic [7:0] err_count;
    logic [7:0] frame_count;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    hierarchical_dot_dec #(
        .W    (8),
        .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_val    (out_val),
        .out_err    (out_err),
        .out_last   (out_last),
        .err_count  (err_count),
        .frame_count(frame_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_val !== 7'h00)    begin n_bad++; $display("FAIL reset_out_val got %h want 00", out_val); end
        n_cmp++; if (out_err !== 1'b0)     begin n_bad++; $display("FAIL reset_out_err got %b want 0", out_err); end
        n_cmp++; if (out_last !== 1'b0)    begin n_bad++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_cmp++; if (err_count !== 8'h00)  begin n_bad++; $display("FAIL reset_err_count got %h want 00", err_count); end
        n_cmp++; if (frame_count !== 8'h00) begin n_bad++; $display("FAIL reset_frame_count got %h want 00", frame_count); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic_decode();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 8'h03; in_last = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_val !== 7'h01 || out_err !== 1'b0 || out_last !== 1'b0)
            begin n_bad++; $display("FAIL basic_beat0 got v%b %h e%b l%b want v1 01 e0 l0", out_valid, out_val, out_err, out_last); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_open got %b want 1", busy); end
        in_code = 8'hFF;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_val !== 7'h7F || out_err !== 1'b0 || out_last !== 1'b0)
            begin n_bad++; $display("FAIL basic_beat1 got v%b %h e%b l%b want v1 7f e0 l0", out_valid, out_val, out_err, out_last); end
        in_code = 8'h01; in_last = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_val !== 7'h00 || out_err !== 1'b0 || out_last !== 1'b1)
            begin n_bad++; $display("FAIL basic_beat2 got v%b %h e%b l%b want v1 00 e0 l1", out_valid, out_val, out_err, out_last); end
        n_cmp++; if (frame_count !== 8'h01) begin n_bad++; $display("FAIL basic_frame_count got %h want 01", frame_count); end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drained got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy got %b want 0", busy); end
        n_cmp++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL basic_err_count got %h want 00", err_count); end
    endtask

    task automatic test_malformed();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 8'h04; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_val !== 7'h02 || out_err !== 1'b1 || out_last !== 1'b1)
            begin n_bad++; $display("FAIL malformed_beat got v%b %h e%b l%b want v1 02 e1 l1", out_valid, out_val, out_err, out_last); end
        n_cmp++; if (err_count !== 8'h01) begin n_bad++; $display("FAIL malformed_err_count got %h want 01", err_count); end
        n_cmp++; if (frame_count !== 8'h01) begin n_bad++; $display("FAIL malformed_frame_count got %h want 01", frame_count); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'd3;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after1 got %b want 1", in_ready); end
        in_code = 8'd5;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_after2 got %b want 0", in_ready); end
        in_code = 8'd7;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_held got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_val !== 7'h01)
            begin n_bad++; $display("FAIL bp_head_stable got v%b %h want v1 01", out_valid, out_val); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_recover got %b want 1", in_ready); end
        n_cmp++; if (out_val !== 7'h02) begin n_bad++; $display("FAIL bp_second got %h want 02", out_val); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_val !== 7'h03)
            begin n_bad++; $display("FAIL bp_third got v%b %h want v1 03", out_valid, out_val); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_duplicate got %b want 0", out_valid); end
    endtask

    task automatic test_counter_limits();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 8'h00; in_last = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        n_cmp++; if (err_count !== 8'hFF || frame_count !== 8'hFF)
            begin n_bad++; $display("FAIL limit_255 got err %h frm %h want ff ff", err_count, frame_count); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++; if (err_count !== 8'hFF) begin n_bad++; $display("FAIL limit_err_sat got %h want ff", err_count); end
        n_cmp++; if (frame_count !== 8'h00) begin n_bad++; $display("FAIL limit_frame_wrap got %h want 00", frame_count); end
        tick();
    endtask

    task automatic test_mid_frame_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'h02; in_last = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || err_count !== 8'h02)
            begin n_bad++; $display("FAIL midrst_pre got busy %b err %h want 1 02", busy, err_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            begin n_bad++; $display("FAIL midrst_post got v%b busy %b rdy %b want 0 0 1", out_valid, busy, in_ready); end
        n_cmp++; if (err_count !== 8'h00 || frame_count !== 8'h00)
            begin n_bad++; $display("FAIL midrst_counts got err %h frm %h want 00 00", err_count, frame_count); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 8'h01; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++; if (frame_count !== 8'h01 || out_last !== 1'b1 || out_val !== 7'h00)
            begin n_bad++; $display("FAIL midrst_next_frame got frm %h l%b %h want 01 l1 00", frame_count, out_last, out_val); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'h09;
        tick();
        out_ready = 1'b1;
        in_code   = 8'h0B;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_val !== 7'h05 || in_ready !== 1'b1)
            begin n_bad++; $display("FAIL pp_after got v%b %h rdy %b want v1 05 1", out_valid, out_val, in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_val !== 7'h05)
            begin n_bad++; $display("FAIL pp_count1 got v%b rdy %b %h want v1 1 05", out_valid, in_ready, out_val); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pp_single_entry got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_malformed();
        test_backpressure();
        test_counter_limits();
        test_mid_frame_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
